// File: rtl/calc_pkg.sv
// Shared constants and types for the iterative multiply-accumulate / divide unit.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } calc_state_t;

  localparam logic [CALC_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/calc_div_core.sv
// Restoring divider, one quotient bit per step; outputs show the value after the current step
// so the owner can capture the final result on the last step edge.
module calc_div_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   trial;
  logic             fits;

  // quo_q doubles as the dividend shift register: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    fits  = (trial >= {1'b0, dvs_q});
    rem_d = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], fits};
  end

  assign quo_o = quo_d;
  assign rem_o = rem_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/calc_unit_8.sv
// Iterative unsigned calculator: {cout,prod} = a*b + cin and quo/rem = a/b, one bit per clock.
// Optional CALC_DIV_ZERO_FLAG_EN adds a registered div_zero output.
module calc_unit_8
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
`ifdef CALC_DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  calc_state_t        state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   quo_next, rem_next;
  logic               load, step, last;

  assign last     = (cnt_q == CntW'(WIDTH - 1));
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Shift-add multiplier; seeding the accumulator with cin folds the addend in for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      cnt_q    <= '0;
      acc_q    <= {{WIDTH{1'b0}}, cin};
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (step) begin
      cnt_q    <= cnt_q + CntW'(1);
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  calc_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (a),
    .divisor_i  (b),
    .quo_o      (quo_next),
    .rem_o      (rem_next)
  );

  // Result registers change only on the final step, so partial values are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      cout <= '0;
      quo  <= '0;
      rem  <= '0;
    end else if (step && last) begin
      prod <= acc_next[WIDTH-1:0];
      cout <= acc_next[2*WIDTH-1:WIDTH];
      quo  <= quo_next;
      rem  <= rem_next;
    end
  end

`ifdef CALC_DIV_ZERO_FLAG_EN
  logic bzero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bzero_q  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (load) bzero_q <= (b == '0);
      if (step && last) div_zero <= bzero_q;
    end
  end
`endif

endmodule

// File: tb/tb_calc_unit_8.sv
// Directed self-checking bench for calc_unit_8 with a small arithmetic reference model.
module tb_calc_unit_8;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a, b, cin;
  logic       busy, done;
  logic [7:0] prod, cout, quo, rem;
`ifdef CALC_DIV_ZERO_FLAG_EN
  logic       div_zero;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  calc_unit_8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .prod  (prod),
    .cout  (cout),
    .quo   (quo),
    .rem   (rem)
`ifdef CALC_DIV_ZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives start for one edge; returns at the negedge after the sampling edge.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tbv, input logic [7:0] tc);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tbv;
    cin   = tc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called one cycle after the start edge; done is due 8 cycles later.
  task automatic wait_done(input string tag);
    int cycles;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_latency"}, cycles, 9);
  endtask

  task automatic check_res(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                           input logic [7:0] tc);
    logic [15:0] mac;
    logic [7:0]  eq, er;
    mac = 16'(ta) * 16'(tbv) + 16'(tc);
    eq  = (tbv == 8'd0) ? DIV_ZERO_QUO : ta / tbv;
    er  = (tbv == 8'd0) ? ta : ta % tbv;
    chk({tag, "_prod"}, prod, mac[7:0]);
    chk({tag, "_cout"}, cout, mac[15:8]);
    chk({tag, "_quo"}, quo, eq);
    chk({tag, "_rem"}, rem, er);
`ifdef CALC_DIV_ZERO_FLAG_EN
    chk({tag, "_dz"}, div_zero, (tbv == 8'd0));
`endif
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic [7:0] tc);
    launch(ta, tbv, tc);
    wait_done(tag);
    check_res(tag, ta, tbv, tc);
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb, rc;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {prod, cout, quo, rem}, 0);
    rst = 1'b0;

    // Directed arithmetic vectors with hand-computed results.
    launch(8'd12, 8'd13, 8'd7);
    chk("v1_busy", busy, 1);
    wait_done("v1");
    chk("v1_res", {cout, prod, quo, rem}, 32'h00A3_000C);
    @(negedge clk);
    chk("v1_pulse", done, 0);
    chk("v1_idle", busy, 0);

    launch(8'd255, 8'd255, 8'd255);
    wait_done("v2");
    chk("v2_res", {cout, prod, quo, rem}, 32'hFF00_0100);

    launch(8'd200, 8'd7, 8'd0);
    wait_done("v3");
    chk("v3_res", {cout, prod, quo, rem}, 32'h0578_1C04);

    launch(8'd77, 8'd0, 8'd9);
    wait_done("v4");
    chk("v4_res", {cout, prod, quo, rem}, 32'h0009_FF4D);
`ifdef CALC_DIV_ZERO_FLAG_EN
    chk("v4_dz", div_zero, 1);
`endif
    @(negedge clk);
    chk("v4_hold", {cout, prod, quo, rem}, 32'h0009_FF4D);

    // start held high with changing operands during RUN.
    @(negedge clk);
    start = 1'b1; a = 8'd12; b = 8'd13; cin = 8'd7;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      a = 8'(i * 37); b = 8'(i * 11 + 1); cin = 8'(i);
      if (i == 8) start = 1'b0;
    end
    @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_res", {cout, prod, quo, rem}, 32'h00A3_000C);
    @(negedge clk);
    chk("hold_pulse", done, 0);

    // Back-to-back: start accepted in the DONE cycle.
    launch(8'd200, 8'd7, 8'd0);
    wait_done("b2b1");
    start = 1'b1; a = 8'd100; b = 8'd9; cin = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_keep", {cout, prod, quo, rem}, 32'h0578_1C04);
    wait_done("b2b2");
    check_res("b2b2", 8'd100, 8'd9, 8'd3);

    // Reset in the 4th RUN cycle aborts with no done.
    launch(8'd250, 8'd3, 8'd1);
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {prod, cout, quo, rem}, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_nodone", seen, 0);

    // Random sweep; every eighth divisor forced to zero.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 8 == 0) ? 8'd0 : 8'($urandom);
      rc = 8'($urandom);
      run_op("rnd", ra, rb, rc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
